// File: rtl/e203_csr_pkg.sv
// Shared CSR constants for the EXU trap/debug CSR bank.
// CSR indices, mstatus/mie/dcsr bit positions and the MISA value.
package e203_csr_pkg;

  localparam int CSR_IDX_W = 12;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_DCSR      = 12'h7B0;
  localparam logic [11:0] CSR_DPC       = 12'h7B1;
  localparam logic [11:0] CSR_DSCRATCH  = 12'h7B2;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  localparam int DCSR_STEP     = 2;
  localparam int DCSR_CAUSE_LO = 6;
  localparam int DCSR_CAUSE_HI = 8;
  localparam int DCSR_EBREAKM  = 15;

  localparam logic [3:0]  DCSR_XDEBUGVER = 4'h4;
  localparam logic [31:0] MISA_VAL       = 32'h4000_1104;

  localparam logic [31:0] PC_ALIGN_MASK   = 32'hFFFF_FFFE;
  localparam logic [31:0] MTVEC_MODE_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/e203_exu_trapcsr_if.sv
// Software CSR access port of the trap/debug CSR bank.
// master: requester (EXU CSR ctrl); slave: the CSR bank.
interface e203_exu_trapcsr_if
  import e203_csr_pkg::*;
;
  logic                 csr_ena;
  logic                 csr_wr_en;
  logic                 csr_rd_en;
  logic [CSR_IDX_W-1:0] csr_idx;
  logic [31:0]          wbck_csr_dat;
  logic [31:0]          read_csr_dat;
  logic                 csr_access_ilgl;

  modport master (
    output csr_ena,
    output csr_wr_en,
    output csr_rd_en,
    output csr_idx,
    output wbck_csr_dat,
    input  read_csr_dat,
    input  csr_access_ilgl
  );

  modport slave (
    input  csr_ena,
    input  csr_wr_en,
    input  csr_rd_en,
    input  csr_idx,
    input  wbck_csr_dat,
    output read_csr_dat,
    output csr_access_ilgl
  );

endinterface

// File: rtl/e203_exu_trapcsr_cnt64.sv
// 64-bit counter built from two writable 32-bit halves.
// Ports: inc_en/inhibit gate counting; wr_lo/wr_hi load wdat.
module e203_exu_trapcsr_cnt64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic        inhibit,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdat,
  output logic [63:0] cnt
);

  logic wr_any;

  assign wr_any = wr_lo | wr_hi;

  // A half write suppresses that cycle's increment of the
  // whole counter, so software sees exactly what it wrote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wr_any) begin
      if (wr_lo) cnt[31:0]  <= wdat;
      if (wr_hi) cnt[63:32] <= wdat;
    end else if (inc_en & ~inhibit) begin
      cnt <= cnt + 64'd1;
    end
  end

endmodule

// File: rtl/e203_exu_trapcsr.sv
// Machine-mode trap/debug CSR bank with mcycle/minstret.
// Ports: clk/rst_n, csr (software port), cmt_* trap updates, CSR state out.
module e203_exu_trapcsr
  import e203_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST    = 32'h0000_0000,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  e203_exu_trapcsr_if.slave   csr,
  input  logic                cmt_epc_ena,
  input  logic [31:0]         cmt_epc,
  input  logic                cmt_cause_ena,
  input  logic [31:0]         cmt_cause,
  input  logic                cmt_badaddr_ena,
  input  logic [31:0]         cmt_badaddr,
  input  logic                cmt_status_ena,
  input  logic                cmt_mret_ena,
  input  logic                cmt_dpc_ena,
  input  logic [31:0]         cmt_dpc,
  input  logic                cmt_dcause_ena,
  input  logic [2:0]          cmt_dcause,
  input  logic                cmt_dret_ena,
  input  logic                cmt_instret_ena,
  output logic [31:0]         csr_mtvec_r,
  output logic [31:0]         csr_mepc_r,
  output logic [31:0]         csr_dpc_r,
  output logic                status_mie_r,
  output logic                mtie_r,
  output logic                msie_r,
  output logic                meie_r,
  output logic                dbg_mode,
  output logic                dbg_step_r,
  output logic                dbg_ebreakm_r
);

  logic sel_mstatus, sel_misa, sel_mie;
  logic sel_mtvec, sel_mscratch, sel_mepc;
  logic sel_mcause, sel_mtval, sel_mip;
  logic sel_mcycle, sel_mcycleh;
  logic sel_minstret, sel_minstreth;
  logic sel_dcsr, sel_dpc, sel_dscratch;
  logic sel_mhartid;
  logic csr_hit;
  logic wr_ok;

  assign sel_mstatus   = csr.csr_idx == CSR_MSTATUS;
  assign sel_misa      = csr.csr_idx == CSR_MISA;
  assign sel_mie       = csr.csr_idx == CSR_MIE;
  assign sel_mtvec     = csr.csr_idx == CSR_MTVEC;
  assign sel_mscratch  = csr.csr_idx == CSR_MSCRATCH;
  assign sel_mepc      = csr.csr_idx == CSR_MEPC;
  assign sel_mcause    = csr.csr_idx == CSR_MCAUSE;
  assign sel_mtval     = csr.csr_idx == CSR_MTVAL;
  assign sel_mip       = csr.csr_idx == CSR_MIP;
  assign sel_mcycle    = csr.csr_idx == CSR_MCYCLE;
  assign sel_mcycleh   = csr.csr_idx == CSR_MCYCLEH;
  assign sel_minstret  = csr.csr_idx == CSR_MINSTRET;
  assign sel_minstreth = csr.csr_idx == CSR_MINSTRETH;
  assign sel_dcsr      = csr.csr_idx == CSR_DCSR;
  assign sel_dpc       = csr.csr_idx == CSR_DPC;
  assign sel_dscratch  = csr.csr_idx == CSR_DSCRATCH;
  assign sel_mhartid   = csr.csr_idx == CSR_MHARTID;

  assign csr_hit = sel_mstatus | sel_misa | sel_mie
                 | sel_mtvec | sel_mscratch | sel_mepc
                 | sel_mcause | sel_mtval | sel_mip
                 | sel_mcycle | sel_mcycleh
                 | sel_minstret | sel_minstreth
                 | sel_dcsr | sel_dpc | sel_dscratch
                 | sel_mhartid;

  assign csr.csr_access_ilgl = csr.csr_ena & ~csr_hit;

  // Unimplemented indices never match a select, so the
  // per-register strobes below already drop their writes.
  assign wr_ok = csr.csr_ena & csr.csr_wr_en;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch;
  logic wr_mepc, wr_mcause, wr_mtval;
  logic wr_dcsr, wr_dpc, wr_dscratch;
  logic wr_mcycle, wr_mcycleh;
  logic wr_minstret, wr_minstreth;

  assign wr_mstatus   = wr_ok & sel_mstatus;
  assign wr_mie       = wr_ok & sel_mie;
  assign wr_mtvec     = wr_ok & sel_mtvec;
  assign wr_mscratch  = wr_ok & sel_mscratch;
  assign wr_mepc      = wr_ok & sel_mepc;
  assign wr_mcause    = wr_ok & sel_mcause;
  assign wr_mtval     = wr_ok & sel_mtval;
  assign wr_dcsr      = wr_ok & sel_dcsr;
  assign wr_dpc       = wr_ok & sel_dpc;
  assign wr_dscratch  = wr_ok & sel_dscratch;
  assign wr_mcycle    = wr_ok & sel_mcycle;
  assign wr_mcycleh   = wr_ok & sel_mcycleh;
  assign wr_minstret  = wr_ok & sel_minstret;
  assign wr_minstreth = wr_ok & sel_minstreth;

  logic [31:0] wdat;

  assign wdat = csr.wbck_csr_dat;

  logic [31:0] mtvec_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] mscratch_q, dpc_q, dscratch_q;
  logic        mie_q, mpie_q;
  logic        msie_q, mtie_q, meie_q;
  logic        dbg_mode_q, step_q, ebreakm_q;
  logic [2:0]  dcause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec_q    <= MTVEC_RST & MTVEC_MODE_MASK;
      mscratch_q <= '0;
      dscratch_q <= '0;
      msie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      meie_q     <= 1'b0;
    end else begin
      if (wr_mtvec)    mtvec_q    <= wdat & MTVEC_MODE_MASK;
      if (wr_mscratch) mscratch_q <= wdat;
      if (wr_dscratch) dscratch_q <= wdat;
      if (wr_mie) begin
        msie_q <= wdat[MIE_MSIE];
        mtie_q <= wdat[MIE_MTIE];
        meie_q <= wdat[MIE_MEIE];
      end
    end
  end

  // Commit-time trap updates override a same-cycle software write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      if (cmt_epc_ena)  mepc_q <= cmt_epc & PC_ALIGN_MASK;
      else if (wr_mepc) mepc_q <= wdat & PC_ALIGN_MASK;
      if (cmt_cause_ena)  mcause_q <= cmt_cause;
      else if (wr_mcause) mcause_q <= wdat;
      if (cmt_badaddr_ena) mtval_q <= cmt_badaddr;
      else if (wr_mtval)   mtval_q <= wdat;
    end
  end

  // Trap entry beats mret if upstream ever raises both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
    end else if (cmt_status_ena) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (cmt_mret_ena) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (wr_mstatus) begin
      mie_q  <= wdat[MSTATUS_MIE];
      mpie_q <= wdat[MSTATUS_MPIE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_mode_q <= 1'b0;
      dpc_q      <= '0;
      dcause_q   <= '0;
      step_q     <= 1'b0;
      ebreakm_q  <= 1'b0;
    end else begin
      if (cmt_dpc_ena)       dbg_mode_q <= 1'b1;
      else if (cmt_dret_ena) dbg_mode_q <= 1'b0;
      if (cmt_dpc_ena) dpc_q <= cmt_dpc & PC_ALIGN_MASK;
      else if (wr_dpc) dpc_q <= wdat & PC_ALIGN_MASK;
      if (cmt_dcause_ena) dcause_q <= cmt_dcause;
      // dcsr is only writable from debug mode; elsewhere the
      // write is silently ignored rather than trapped.
      if (wr_dcsr & dbg_mode_q) begin
        step_q    <= wdat[DCSR_STEP];
        ebreakm_q <= wdat[DCSR_EBREAKM];
      end
    end
  end

  logic [63:0] mcycle, minstret;

  if (HAS_COUNTERS) begin : g_cnt
    e203_exu_trapcsr_cnt64 u_mcycle (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_en  (1'b1),
      .inhibit (dbg_mode_q),
      .wr_lo   (wr_mcycle),
      .wr_hi   (wr_mcycleh),
      .wdat    (wdat),
      .cnt     (mcycle)
    );
    e203_exu_trapcsr_cnt64 u_minstret (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_en  (cmt_instret_ena),
      .inhibit (dbg_mode_q),
      .wr_lo   (wr_minstret),
      .wr_hi   (wr_minstreth),
      .wdat    (wdat),
      .cnt     (minstret)
    );
  end else begin : g_nocnt
    assign mcycle   = '0;
    assign minstret = '0;
  end

  logic [31:0] mstatus_rd, mie_rd, dcsr_rd;

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mie_q;
    mstatus_rd[MSTATUS_MPIE] = mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    mie_rd = '0;
    mie_rd[MIE_MSIE] = msie_q;
    mie_rd[MIE_MTIE] = mtie_q;
    mie_rd[MIE_MEIE] = meie_q;
  end

  always_comb begin
    dcsr_rd = '0;
    dcsr_rd[31:28] = DCSR_XDEBUGVER;
    dcsr_rd[DCSR_EBREAKM] = ebreakm_q;
    dcsr_rd[DCSR_CAUSE_HI:DCSR_CAUSE_LO] = dcause_q;
    dcsr_rd[DCSR_STEP] = step_q;
  end

  logic [31:0] rdat;

  always_comb begin
    rdat = '0;
    unique case (1'b1)
      sel_mstatus:   rdat = mstatus_rd;
      sel_misa:      rdat = MISA_VAL;
      sel_mie:       rdat = mie_rd;
      sel_mtvec:     rdat = mtvec_q;
      sel_mscratch:  rdat = mscratch_q;
      sel_mepc:      rdat = mepc_q;
      sel_mcause:    rdat = mcause_q;
      sel_mtval:     rdat = mtval_q;
      sel_mcycle:    rdat = mcycle[31:0];
      sel_mcycleh:   rdat = mcycle[63:32];
      sel_minstret:  rdat = minstret[31:0];
      sel_minstreth: rdat = minstret[63:32];
      sel_dcsr:      rdat = dcsr_rd;
      sel_dpc:       rdat = dpc_q;
      sel_dscratch:  rdat = dscratch_q;
      default:       rdat = '0;
    endcase
  end

  assign csr.read_csr_dat =
    (csr.csr_ena & csr.csr_rd_en) ? rdat : '0;

  assign csr_mtvec_r   = mtvec_q;
  assign csr_mepc_r    = mepc_q;
  assign csr_dpc_r     = dpc_q;
  assign status_mie_r  = mie_q;
  assign msie_r        = msie_q;
  assign mtie_r        = mtie_q;
  assign meie_r        = meie_q;
  assign dbg_mode      = dbg_mode_q;
  assign dbg_step_r    = step_q;
  assign dbg_ebreakm_r = ebreakm_q;

endmodule

// File: tb/tb_e203_exu_trapcsr.sv
// Scoreboard bench for e203_exu_trapcsr: directed plan + random.
// Driver pushes model expectations; negedge monitor compares.
module tb_e203_exu_trapcsr;

  localparam logic [31:0] MTVEC_RST = 32'h8000_0101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  e203_exu_trapcsr_if csr_if ();

  logic        cmt_epc_ena = 0;
  logic [31:0] cmt_epc = 0;
  logic        cmt_cause_ena = 0;
  logic [31:0] cmt_cause = 0;
  logic        cmt_badaddr_ena = 0;
  logic [31:0] cmt_badaddr = 0;
  logic        cmt_status_ena = 0;
  logic        cmt_mret_ena = 0;
  logic        cmt_dpc_ena = 0;
  logic [31:0] cmt_dpc = 0;
  logic        cmt_dcause_ena = 0;
  logic [2:0]  cmt_dcause = 0;
  logic        cmt_dret_ena = 0;
  logic        cmt_instret_ena = 0;

  logic [31:0] csr_mtvec_r, csr_mepc_r, csr_dpc_r;
  logic status_mie_r, mtie_r, msie_r, meie_r;
  logic dbg_mode, dbg_step_r, dbg_ebreakm_r;

  e203_exu_trapcsr #(
    .MTVEC_RST    (MTVEC_RST),
    .HAS_COUNTERS (1'b1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr             (csr_if),
    .cmt_epc_ena     (cmt_epc_ena),
    .cmt_epc         (cmt_epc),
    .cmt_cause_ena   (cmt_cause_ena),
    .cmt_cause       (cmt_cause),
    .cmt_badaddr_ena (cmt_badaddr_ena),
    .cmt_badaddr     (cmt_badaddr),
    .cmt_status_ena  (cmt_status_ena),
    .cmt_mret_ena    (cmt_mret_ena),
    .cmt_dpc_ena     (cmt_dpc_ena),
    .cmt_dpc         (cmt_dpc),
    .cmt_dcause_ena  (cmt_dcause_ena),
    .cmt_dcause      (cmt_dcause),
    .cmt_dret_ena    (cmt_dret_ena),
    .cmt_instret_ena (cmt_instret_ena),
    .csr_mtvec_r     (csr_mtvec_r),
    .csr_mepc_r      (csr_mepc_r),
    .csr_dpc_r       (csr_dpc_r),
    .status_mie_r    (status_mie_r),
    .mtie_r          (mtie_r),
    .msie_r          (msie_r),
    .meie_r          (meie_r),
    .dbg_mode        (dbg_mode),
    .dbg_step_r      (dbg_step_r),
    .dbg_ebreakm_r   (dbg_ebreakm_r)
  );

  // Reference model: architectural register values.
  logic [31:0] m_mepc, m_mcause, m_mtval, m_mscratch;
  logic [31:0] m_mtvec, m_mie, m_dpc, m_dscratch;
  logic        m_st_mie, m_st_mpie;
  logic [2:0]  m_dcause;
  logic        m_step, m_ebreakm, m_dbg;
  logic [63:0] m_cycle, m_instret;

  typedef struct {
    logic [31:0] rd;
    logic        ilgl;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] dpc;
    logic [6:0]  flags;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [11:0] idx_tab [0:16] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
    12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
    12'hB82, 12'h7B0, 12'h7B1, 12'h7B2, 12'hF14
  };

  function automatic bit legal(logic [11:0] i);
    for (int k = 0; k < 17; k++)
      if (idx_tab[k] == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] i);
    case (i)
      12'h300: return 32'h1800 | (32'(m_st_mpie) << 7)
                               | (32'(m_st_mie) << 3);
      12'h301: return 32'h4000_1104;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      12'h7B0: return 32'h4000_0000 | (32'(m_ebreakm) << 15)
                    | (32'(m_dcause) << 6) | (32'(m_step) << 2);
      12'h7B1: return m_dpc;
      12'h7B2: return m_dscratch;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
    m_mtvec = {MTVEC_RST[31:2], 2'b00};
    m_mie = 0; m_dpc = 0; m_dscratch = 0;
    m_st_mie = 0; m_st_mpie = 0; m_dcause = 0;
    m_step = 0; m_ebreakm = 0; m_dbg = 0;
    m_cycle = 0; m_instret = 0;
  endtask

  // Advance the model by one clock edge using the inputs
  // that were present at that edge.
  task automatic model_step();
    logic wr;
    logic [11:0] i;
    logic [31:0] d;
    logic was_dbg;
    logic cnt_wr, ins_wr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    i = csr_if.csr_idx;
    d = csr_if.wbck_csr_dat;
    wr = csr_if.csr_ena && csr_if.csr_wr_en && legal(i);
    was_dbg = m_dbg;
    if (cmt_epc_ena) m_mepc = {cmt_epc[31:1], 1'b0};
    else if (wr && i == 12'h341) m_mepc = {d[31:1], 1'b0};
    if (cmt_cause_ena) m_mcause = cmt_cause;
    else if (wr && i == 12'h342) m_mcause = d;
    if (cmt_badaddr_ena) m_mtval = cmt_badaddr;
    else if (wr && i == 12'h343) m_mtval = d;
    if (wr && i == 12'h340) m_mscratch = d;
    if (wr && i == 12'h7B2) m_dscratch = d;
    if (wr && i == 12'h305) m_mtvec = {d[31:2], 2'b00};
    if (wr && i == 12'h304) m_mie = d & 32'h0000_0888;
    if (cmt_status_ena) begin
      m_st_mpie = m_st_mie; m_st_mie = 0;
    end else if (cmt_mret_ena) begin
      m_st_mie = m_st_mpie; m_st_mpie = 1;
    end else if (wr && i == 12'h300) begin
      m_st_mie = d[3]; m_st_mpie = d[7];
    end
    if (cmt_dpc_ena) m_dpc = {cmt_dpc[31:1], 1'b0};
    else if (wr && i == 12'h7B1) m_dpc = {d[31:1], 1'b0};
    if (cmt_dcause_ena) m_dcause = cmt_dcause;
    if (wr && i == 12'h7B0 && was_dbg) begin
      m_step = d[2]; m_ebreakm = d[15];
    end
    if (cmt_dpc_ena) m_dbg = 1;
    else if (cmt_dret_ena) m_dbg = 0;
    cnt_wr = wr && (i == 12'hB00 || i == 12'hB80);
    ins_wr = wr && (i == 12'hB02 || i == 12'hB82);
    if (cnt_wr) begin
      if (i == 12'hB00) m_cycle[31:0] = d;
      else m_cycle[63:32] = d;
    end else if (!was_dbg) begin
      m_cycle = m_cycle + 1;
    end
    if (ins_wr) begin
      if (i == 12'hB02) m_instret[31:0] = d;
      else m_instret[63:32] = d;
    end else if (!was_dbg && cmt_instret_ena) begin
      m_instret = m_instret + 1;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    logic [11:0] i;
    if (!rst_n) model_reset();
    i = csr_if.csr_idx;
    e.rd = (csr_if.csr_ena && csr_if.csr_rd_en && legal(i))
         ? m_read(i) : 32'h0;
    e.ilgl = csr_if.csr_ena && !legal(i);
    e.mtvec = m_mtvec;
    e.mepc = m_mepc;
    e.dpc = m_dpc;
    e.flags = {m_st_mie, m_mie[7], m_mie[3], m_mie[11],
               m_dbg, m_step, m_ebreakm};
    q.push_back(e);
  endtask

  task automatic step();
    push_exp();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cmt_epc_ena = 0; cmt_cause_ena = 0; cmt_badaddr_ena = 0;
    cmt_status_ena = 0; cmt_mret_ena = 0; cmt_dpc_ena = 0;
    cmt_dcause_ena = 0; cmt_dret_ena = 0; cmt_instret_ena = 0;
    csr_if.csr_ena = 0; csr_if.csr_wr_en = 0;
    csr_if.csr_rd_en = 0; csr_if.csr_idx = 0;
    csr_if.wbck_csr_dat = 0;
  endtask

  task automatic wr(logic [11:0] i, logic [31:0] d);
    idle();
    csr_if.csr_ena = 1; csr_if.csr_wr_en = 1;
    csr_if.csr_idx = i; csr_if.wbck_csr_dat = d;
  endtask

  task automatic rd(logic [11:0] i);
    idle();
    csr_if.csr_ena = 1; csr_if.csr_rd_en = 1;
    csr_if.csr_idx = i;
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    n_vec++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("read_csr_dat", csr_if.read_csr_dat, e.rd);
      chk("csr_access_ilgl", 32'(csr_if.csr_access_ilgl),
          32'(e.ilgl));
      chk("csr_mtvec_r", csr_mtvec_r, e.mtvec);
      chk("csr_mepc_r", csr_mepc_r, e.mepc);
      chk("csr_dpc_r", csr_dpc_r, e.dpc);
      chk("flags", 32'({status_mie_r, mtie_r, msie_r, meie_r,
                        dbg_mode, dbg_step_r, dbg_ebreakm_r}),
          32'(e.flags));
    end
  end

  initial begin
    csr_if.csr_ena = 0; csr_if.csr_wr_en = 0;
    csr_if.csr_rd_en = 0; csr_if.csr_idx = 0;
    csr_if.wbck_csr_dat = 0;
    model_reset();
    @(posedge clk);
    #1;
    idle(); rst_n = 0; step(); step();
    rst_n = 1; rd(12'h305); step();
    wr(12'h300, 32'h8); step();
    rd(12'h300);
    cmt_status_ena = 1; cmt_epc_ena = 1; cmt_epc = 32'h8000_0103;
    cmt_cause_ena = 1; cmt_cause = 32'h8000_000B;
    step();
    rd(12'h300); step();
    rd(12'h342); step();
    rd(12'h300); cmt_mret_ena = 1; step();
    rd(12'h300); step();
    wr(12'h341, 32'h1234); cmt_epc_ena = 1; cmt_epc = 32'h40;
    step();
    rd(12'h341); step();
    wr(12'h7B0, 32'h8004); step();
    rd(12'h7B0); step();
    idle(); cmt_dpc_ena = 1; cmt_dpc = 32'h200;
    cmt_dcause_ena = 1; cmt_dcause = 3'd3; step();
    rd(12'hB00); cmt_instret_ena = 1; step();
    rd(12'hB00); step();
    wr(12'h7B0, 32'h8004); step();
    rd(12'h7B0); step();
    idle(); cmt_dret_ena = 1; step();
    wr(12'hB80, 32'hFFFF_FFFF); step();
    wr(12'hB00, 32'hFFFF_FFFE); step();
    rd(12'hB00); step();
    rd(12'hB00); step();
    rd(12'hB80); step();
    rd(12'h7FF); step();
    wr(12'h7FF, 32'hDEAD_BEEF); csr_if.csr_rd_en = 1; step();
    wr(12'h304, 32'hFFFF_FFFF); step();
    wr(12'h305, 32'h1234_5677); step();
    idle(); cmt_dpc_ena = 1; cmt_dpc = 32'h301; step();
    wr(12'h300, 32'h88); rst_n = 0; step();
    idle(); rst_n = 1; rd(12'h304); step();

    for (int n = 0; n < 2000; n++) begin
      idle();
      rst_n = ($urandom_range(0, 299) != 0);
      cmt_epc_ena = ($urandom_range(0, 9) == 0);
      cmt_epc = $urandom;
      cmt_cause_ena = ($urandom_range(0, 9) == 0);
      cmt_cause = $urandom;
      cmt_badaddr_ena = ($urandom_range(0, 9) == 0);
      cmt_badaddr = $urandom;
      cmt_status_ena = ($urandom_range(0, 7) == 0);
      cmt_mret_ena = ($urandom_range(0, 7) == 0);
      cmt_dpc_ena = ($urandom_range(0, 24) == 0);
      cmt_dpc = $urandom;
      cmt_dcause_ena = ($urandom_range(0, 9) == 0);
      cmt_dcause = 3'($urandom);
      cmt_dret_ena = ($urandom_range(0, 7) == 0);
      cmt_instret_ena = 1'($urandom);
      csr_if.csr_ena = ($urandom_range(0, 3) != 0);
      csr_if.csr_wr_en = 1'($urandom);
      csr_if.csr_rd_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        csr_if.csr_idx = 12'($urandom);
      else
        csr_if.csr_idx = idx_tab[$urandom_range(0, 16)];
      csr_if.wbck_csr_dat = $urandom;
      step();
    end

    idle();
    rst_n = 1;
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
